// File: rtl/alu_exec_pipe.sv
// Two-stage ALU execute pipeline: S1 holds operands, S2 holds the registered result.
// Valid/ready handshakes on both sides, a flush that drops in-flight work, and a completion counter.
module alu_exec_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_alu_control,
  input  logic [WIDTH-1:0] in_src_a,
  input  logic [WIDTH-1:0] in_src_b,
  input  logic [4:0]       in_rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [15:0]      done_count
);

  // Returns {illegal, result}; unsupported codes yield a zero result flagged illegal.
  function automatic logic [WIDTH:0] alu_eval(input logic [2:0] code,
                                              input logic signed [WIDTH-1:0] a,
                                              input logic signed [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic             ill;
    r   = '0;
    ill = 1'b0;
    case (code)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b101:  r = {{(WIDTH-1){1'b0}}, (a < b)};
      default: begin
        r   = '0;
        ill = 1'b1;
      end
    endcase
    return {ill, r};
  endfunction

  logic             vld_p1_q, vld_p1_d;
  logic [2:0]       op_p1_q;
  logic [WIDTH-1:0] a_p1_q, b_p1_q;
  logic [4:0]       rd_p1_q;

  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] res_p2_q, res_p2_d;
  logic             zero_p2_q, zero_p2_d;
  logic [4:0]       rd_p2_q, rd_p2_d;
  logic             ill_p2_q, ill_p2_d;

  logic [15:0]      cnt_q, cnt_d;

  logic             in_hs, out_hs, p2_accept, p1_move;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;

  assign out_hs    = vld_p2_q & out_ready;
  assign p2_accept = ~vld_p2_q | out_hs;
  assign p1_move   = vld_p1_q & p2_accept & ~flush;
  assign in_ready  = ~flush & (~vld_p1_q | p1_move);
  assign in_hs     = in_valid & in_ready;

  assign {alu_ill, alu_res} = alu_eval(op_p1_q, a_p1_q, b_p1_q);

  always_comb begin
    vld_p1_d = vld_p1_q;
    if (flush)        vld_p1_d = 1'b0;
    else if (in_hs)   vld_p1_d = 1'b1;
    else if (p1_move) vld_p1_d = 1'b0;
  end

  always_comb begin
    vld_p2_d  = vld_p2_q;
    res_p2_d  = res_p2_q;
    zero_p2_d = zero_p2_q;
    rd_p2_d   = rd_p2_q;
    ill_p2_d  = ill_p2_q;
    if (flush)       vld_p2_d = 1'b0;
    else if (p1_move) begin
      vld_p2_d  = 1'b1;
      res_p2_d  = alu_res;
      zero_p2_d = (alu_res == '0);
      rd_p2_d   = rd_p1_q;
      ill_p2_d  = alu_ill;
    end else if (out_hs) begin
      vld_p2_d = 1'b0;
    end
  end

  // A handshake on the same edge as a flush still counts as completed.
  assign cnt_d = out_hs ? cnt_q + 16'd1 : cnt_q;

  // ---- S1: operand capture ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_p1_q <= 1'b0;
    else          vld_p1_q <= vld_p1_d;
  end

  always_ff @(posedge clk) begin
    if (in_hs) begin
      op_p1_q <= in_alu_control;
      a_p1_q  <= in_src_a;
      b_p1_q  <= in_src_b;
      rd_p1_q <= in_rd;
    end
  end

  // ---- S2: result register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2_q  <= 1'b0;
      res_p2_q  <= '0;
      zero_p2_q <= 1'b0;
      rd_p2_q   <= '0;
      ill_p2_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      vld_p2_q  <= vld_p2_d;
      res_p2_q  <= res_p2_d;
      zero_p2_q <= zero_p2_d;
      rd_p2_q   <= rd_p2_d;
      ill_p2_q  <= ill_p2_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid   = vld_p2_q;
  assign out_result  = res_p2_q;
  assign out_zero    = zero_p2_q;
  assign out_rd      = rd_p2_q;
  assign out_illegal = ill_p2_q;
  assign done_count  = cnt_q;

endmodule

// File: doc/alu_exec_pipe.md
ALU_EXEC_PIPE -- requirements
Module: alu_exec_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: in_valid  input  1  upstream offers an operation.
REQ-005 Port: in_ready  output  1  block accepts the operation this cycle.
REQ-006 Port: in_alu_control  input  3  ALU operation code produced by the ALU decoder.
REQ-007 Port: in_src_a  input  WIDTH  operand A.
REQ-008 Port: in_src_b  input  WIDTH  operand B.
REQ-009 Port: in_rd  input  5  destination register tag, carried through unchanged.
REQ-010 Port: flush  input  1  discard all in-flight operations.
REQ-011 Port: out_valid  output  1  result available.
REQ-012 Port: out_ready  input  1  downstream accepts the result.
REQ-013 Port: out_result  output  WIDTH  ALU result.
REQ-014 Port: out_zero  output  1  out_result equals zero.
REQ-015 Port: out_rd  output  5  destination tag of the result.
REQ-016 Port: out_illegal  output  1  result came from an unsupported code.
REQ-017 Port: done_count  output  16  count of completed output handshakes.

Function
REQ-018 Two stages: S1 operand register (code, A, B, rd, valid); S2 result register (result, zero, rd, illegal, valid).
REQ-019 Input handshake occurs when in_valid & in_ready at a rising edge; the operation is captured into S1.
REQ-020 Output handshake occurs when out_valid & out_ready at a rising edge; S2 is emptied unless refilled that edge.
REQ-021 S2 accepts when S2 is empty or the output handshake occurs that cycle; S1 moves to S2 when S1 is valid and S2 accepts.
REQ-022 in_ready = !flush & (S1 empty | S1 moves this cycle), combinational, no dependence on in_valid.
REQ-023 Latency: with out_ready held high, an operation accepted at edge N appears with out_valid at edge N+1 and completes at edge N+2; throughput one per cycle.
REQ-024 Under backpressure, S2 contents and out_* outputs hold stable while out_valid & !out_ready; no operation is lost or duplicated.
REQ-025 Codes: 000 A+B; 001 A-B; 010 A&B; 011 A|B; 101 signed A<B gives 1, else 0 (zero-extended to WIDTH).
REQ-026 Add and subtract wrap modulo 2^WIDTH; no carry or overflow output.
REQ-027 Codes 100, 110, 111 give result 0, out_zero 1, out_illegal 1; otherwise out_illegal 0.
REQ-028 The result is computed from S1 contents and registered into S2; out_* are driven only from S2 registers.
REQ-029 out_zero is registered with the result and equals (result == 0).
REQ-030 flush high at an edge clears S1 and S2 valid, suppresses the input handshake and S1-to-S2 move, and leaves done_count unchanged unless the output handshake occurs that same edge.
REQ-031 An output handshake coinciding with flush counts as complete.
REQ-032 done_count increments by 1 per output handshake and wraps from 0xFFFF to 0x0000.
REQ-033 Data registers of an empty stage are don't-care; out_result/out_rd/out_zero/out_illegal are checked only while out_valid is 1.

Reset
REQ-034 reset_n low immediately clears S1 and S2 valid, out_valid, out_illegal, and done_count, and drives out_result 0, out_zero 0, out_rd 0, independent of clk.
REQ-035 in_ready is 1 during reset when flush is 0, but no handshake is taken while reset_n is low.
REQ-036 Reset asserted mid-operation discards all in-flight operations; the first edge after deassertion behaves as an empty pipeline.

Verification
REQ-037 Add, out_ready=1: A=5, B=7, code 000, rd=3 -> out_valid two edges later, result 12, zero 0, rd 3, done_count 1.
REQ-038 Sub/zero/wrap: A=B=0x10, code 001 -> result 0, zero 1; then A=0, B=1, code 001 -> result 0xFFFFFFFF.
REQ-039 SLT signed: A=0xFFFFFFFF, B=1, code 101 -> result 1; swapped operands -> result 0; code 110 -> result 0, illegal 1.
REQ-040 Backpressure: stream 4 ops with out_ready=0 -> in_ready falls after 2 accepts, outputs hold stable; release out_ready -> all 4 results delivered in order, done_count 4.
REQ-041 Flush: 2 ops in flight, flush=1 for one edge with out_ready=0 -> out_valid 0 next cycle, done_count unchanged, next accepted op gives a correct result.
REQ-042 Async reset: assert reset_n=0 between edges with a result pending -> out_valid and done_count read 0 before the next clk edge.
